// File: rtl/apb_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// apb_rr_arbiter_if
//   Bundles the requester-side and APB-master-side signals of the
//   round-robin APB sequencer.
//
//   Requester side : req_valid, req_write, req_addr, req_wdata (to arbiter)
//                    req_ack, req_err, rsp_rdata              (from arbiter)
//   APB master side: start_write, start_read, m_addr, m_wdata (from arbiter)
//                    m_rdata, m_done                          (to arbiter)
//   Status         : busy, grant_id                           (from arbiter)
//
//   modport master : the arbiter's view (drives acks, commands and status)
//   modport slave  : the surrounding logic's view (clients + APB master)
// ---------------------------------------------------------------------------
interface apb_rr_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 8,
  parameter int unsigned DW   = 8
);
  localparam int unsigned IW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ack;
  logic               req_err;
  logic [DW-1:0]      rsp_rdata;

  logic               start_write;
  logic               start_read;
  logic [AW-1:0]      m_addr;
  logic [DW-1:0]      m_wdata;
  logic [DW-1:0]      m_rdata;
  logic               m_done;

  logic               busy;
  logic [IW-1:0]      grant_id;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, m_rdata, m_done,
    output req_ack, req_err, rsp_rdata, start_write, start_read,
           m_addr, m_wdata, busy, grant_id
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, m_rdata, m_done,
    input  req_ack, req_err, rsp_rdata, start_write, start_read,
           m_addr, m_wdata, busy, grant_id
  );
endinterface

// File: rtl/apb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// apb_rr_arbiter
//   Shares one APB master between NREQ requesters. A round-robin pick is
//   made in IDLE, exactly one start_write/start_read is issued, then the
//   arbiter waits for m_done (or TIMEOUT cycles) and returns a one-cycle
//   req_ack to the granted requester with req_err and rsp_rdata.
//
//   Ports:
//     PCLK    : clock, rising edge
//     PRESETn : asynchronous active-low reset
//     bus     : apb_rr_arbiter_if.master (requester, APB master, status)
//
//   Parameters: NREQ (2..8), AW, DW, TIMEOUT (>=2)
// ---------------------------------------------------------------------------
module apb_rr_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb_rr_arbiter_if.master bus
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] last_grant_q, last_grant_d;
  logic [IW-1:0] grant_q, grant_d;
  logic          dir_q, dir_d;
  logic          err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] cand;

  // Round-robin search: first pending request strictly after last_grant,
  // wrapping modulo NREQ, so the last served requester is tried last.
  always_comb begin : rr_pick
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IW'((32'(last_grant_q) + i) % NREQ);
      if (!pick_valid && bus.req_valid[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin : fsm_next
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    dir_d        = dir_q;
    err_d        = err_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          dir_d   = bus.req_write[pick_idx];
          addr_d  = bus.req_addr[32'(pick_idx)*AW +: AW];
          wdata_d = bus.req_wdata[32'(pick_idx)*DW +: DW];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // done has priority over the timeout in the final wait cycle
        if (bus.m_done) begin
          if (!dir_q) begin
            rdata_d = bus.m_rdata;
          end
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin : regs
    if (!PRESETn) begin
      state_q      <= IDLE;
      last_grant_q <= IW'(NREQ - 1);
      grant_q      <= '0;
      dir_q        <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      dir_q        <= dir_d;
      err_q        <= err_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      cnt_q        <= cnt_d;
    end
  end

  // Pulses are decoded from the state register so an asynchronous reset
  // clears them immediately without any extra output flops.
  always_comb begin : out_decode
    bus.req_ack = '0;
    if (state_q == RESP) begin
      bus.req_ack[grant_q] = 1'b1;
    end
    bus.req_err     = (state_q == RESP) && err_q;
    bus.start_write = (state_q == ISSUE) && dir_q;
    bus.start_read  = (state_q == ISSUE) && !dir_q;
    bus.busy        = (state_q != IDLE);
    bus.grant_id    = grant_q;
    bus.m_addr      = addr_q;
    bus.m_wdata     = wdata_q;
    bus.rsp_rdata   = rdata_q;
  end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
module tb_apb_rr_arbiter;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned AW      = 8;
  localparam int unsigned DW      = 8;
  localparam int unsigned TIMEOUT = 16;

  logic PCLK = 1'b0;
  logic PRESETn;
  always #5 PCLK = ~PCLK;

  apb_rr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  apb_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // A transaction is described by its grant edge g (issue cycle = g) and
  // its ack cycle a; every output is derived from those timestamps.
  typedef struct packed {
    logic          act;
    logic          dir;
    logic          err;
    int            ptr;
    int            gid;
    int            g;
    int            a;
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rd;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t n;
    n     = '0;
    n.ptr = NREQ - 1;
    return n;
  endfunction

  function automatic mdl_t mdl_step(mdl_t s, logic [NREQ-1:0] v, logic [NREQ-1:0] w,
                                    logic [NREQ*AW-1:0] ad, logic [NREQ*DW-1:0] wd,
                                    logic done, logic [DW-1:0] rdat);
    mdl_t n;
    int   j;
    bit   found;
    n     = s;
    n.cyc = s.cyc + 1;
    found = 1'b0;
    if (!s.act) begin
      for (int k = 1; k <= NREQ; k++) begin
        j = (s.ptr + k) % NREQ;
        if (!found && v[j]) begin
          found   = 1'b1;
          n.act   = 1'b1;
          n.gid   = j;
          n.dir   = w[j];
          n.addr  = ad[j*AW +: AW];
          n.wdata = wd[j*DW +: DW];
          n.g     = n.cyc;
          n.a     = 0;
        end
      end
    end else if (s.a == 0) begin
      // s.cyc is the cycle just ending; waiting cycles are g+1 .. g+TIMEOUT
      if (s.cyc >= s.g + 1 && done) begin
        n.a   = n.cyc;
        n.err = 1'b0;
        if (!s.dir) n.rd = rdat;
      end else if (s.cyc == s.g + TIMEOUT) begin
        n.a   = n.cyc;
        n.err = 1'b1;
      end
    end else if (n.cyc == s.a + 1) begin
      n.act = 1'b0;
      n.ptr = s.gid;
    end
    return n;
  endfunction

  mdl_t md;
  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) md <= mdl_reset();
    else md <= mdl_step(md, bus.req_valid, bus.req_write, bus.req_addr, bus.req_wdata,
                        bus.m_done, bus.m_rdata);
  end

  logic            m_iss, m_in_ack;
  logic [NREQ-1:0] m_ack;
  assign m_iss    = md.act && (md.cyc == md.g);
  assign m_in_ack = md.act && (md.a != 0) && (md.cyc == md.a);
  assign m_ack    = m_in_ack ? (NREQ'(1) << md.gid) : '0;

  bit cmp_en = 1'b0;
  always @(negedge PCLK) begin
    if (cmp_en) begin
      chk("cyc_ack",     32'(bus.req_ack),     32'(m_ack));
      chk("cyc_err",     32'(bus.req_err),     32'(m_in_ack && md.err));
      chk("cyc_start_w", 32'(bus.start_write), 32'(m_iss && md.dir));
      chk("cyc_start_r", 32'(bus.start_read),  32'(m_iss && !md.dir));
      chk("cyc_busy",    32'(bus.busy),        32'(md.act));
      chk("cyc_grant",   32'(bus.grant_id),    32'(md.gid));
      chk("cyc_m_addr",  32'(bus.m_addr),      32'(md.addr));
      chk("cyc_m_wdata", 32'(bus.m_wdata),     32'(md.wdata));
      chk("cyc_rdata",   32'(bus.rsp_rdata),   32'(md.rd));
    end
  end

  // ---------------- stimulus, APB responder, event logs ----------------
  typedef struct packed {
    int              cyc;
    int              id;
    logic [NREQ-1:0] vec;
    logic            wr;
    logic            err;
    logic [DW-1:0]   rd;
  } ev_t;

  ev_t st_q[$];
  ev_t ak_q[$];
  int  tcyc     = 0;
  int  done_dly = 1;   // 0 = master never answers
  int  done_at  = -1;
  logic [DW-1:0] rd_val = '0;

  task automatic tick();
    ev_t e;
    @(posedge PCLK);
    #1;
    tcyc++;
    if (bus.start_write || bus.start_read) begin
      e     = '0;
      e.cyc = tcyc;
      e.id  = int'(bus.grant_id);
      e.wr  = bus.start_write;
      st_q.push_back(e);
      done_at = (done_dly > 0) ? tcyc + done_dly : -1;
    end
    if (bus.req_ack != '0) begin
      e     = '0;
      e.cyc = tcyc;
      e.vec = bus.req_ack;
      e.err = bus.req_err;
      e.rd  = bus.rsp_rdata;
      for (int i = 0; i < NREQ; i++) if (bus.req_ack[i]) e.id = i;
      ak_q.push_back(e);
      bus.req_valid = bus.req_valid & ~bus.req_ack;
    end
    bus.m_done  = (tcyc == done_at);
    bus.m_rdata = rd_val;
  endtask

  task automatic req(int i, logic wr, logic [AW-1:0] a, logic [DW-1:0] d);
    bus.req_valid[i]           = 1'b1;
    bus.req_write[i]           = wr;
    bus.req_addr[i*AW +: AW]   = a;
    bus.req_wdata[i*DW +: DW]  = d;
  endtask

  task automatic wait_acks(string nm, int n, int budget);
    int b;
    b = 0;
    while (ak_q.size() < n && b < budget) begin
      tick();
      b++;
    end
    chk(nm, 32'(ak_q.size()), 32'(n));
  endtask

  task automatic clear_logs();
    st_q.delete();
    ak_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    PRESETn       = 1'b0;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.m_done    = 1'b0;
    bus.m_rdata   = '0;
    tick();
    cmp_en = 1'b1;
    tick();
    chk("rst_busy",  32'(bus.busy),      32'd0);
    chk("rst_grant", 32'(bus.grant_id),  32'd0);
    chk("rst_addr",  32'(bus.m_addr),    32'd0);
    chk("rst_ack",   32'(bus.req_ack),   32'd0);
    PRESETn = 1'b1;
    tick();

    // 1: single write from requester 0, done two cycles after start
    clear_logs();
    done_dly = 2;
    req(0, 1'b1, 8'h10, 8'hAB);
    wait_acks("t1_acks", 1, 40);
    chk("t1_nstart", 32'(st_q.size()),            32'd1);
    chk("t1_is_wr",  32'(st_q[0].wr),             32'd1);
    chk("t1_lat",    32'(ak_q[0].cyc - st_q[0].cyc), 32'd3);
    chk("t1_ack",    32'(ak_q[0].vec),            32'b0001);
    chk("t1_err",    32'(ak_q[0].err),            32'd0);
    chk("t1_addr",   32'(bus.m_addr),             32'h10);
    chk("t1_wdata",  32'(bus.m_wdata),            32'hAB);

    // 2: read from requester 2
    clear_logs();
    done_dly = 1;
    rd_val   = 8'hAB;
    req(2, 1'b0, 8'h10, 8'h00);
    wait_acks("t2_acks", 1, 40);
    chk("t2_nstart", 32'(st_q.size()),            32'd1);
    chk("t2_is_rd",  32'(st_q[0].wr),             32'd0);
    chk("t2_ack",    32'(ak_q[0].vec),            32'b0100);
    chk("t2_rdata",  32'(ak_q[0].rd),             32'hAB);
    chk("t2_lat",    32'(ak_q[0].cyc - st_q[0].cyc), 32'd2);

    // 3: all four requesters contend straight out of reset
    tick();
    PRESETn = 1'b0;
    rd_val  = 8'h5A;
    req(0, 1'b1, 8'h20, 8'h01);
    req(1, 1'b0, 8'h21, 8'h00);
    req(2, 1'b1, 8'h22, 8'h03);
    req(3, 1'b0, 8'h23, 8'h00);
    tick();
    tick();
    clear_logs();
    PRESETn = 1'b1;
    wait_acks("t3_acks", 4, 100);
    for (int k = 0; k < 4; k++) chk("t3_order", 32'(ak_q[k].id), 32'(k));
    tick();
    tick();
    tick();
    chk("t3_busy_after", 32'(bus.busy),     32'd0);
    chk("t3_nstart",     32'(st_q.size()),  32'd4);
    chk("t3_nack",       32'(ak_q.size()),  32'd4);

    // 4: after requester 2 completes, 3 must beat 1
    clear_logs();
    req(2, 1'b1, 8'h24, 8'h04);
    wait_acks("t4a_acks", 1, 40);
    chk("t4a_id", 32'(ak_q[0].id), 32'd2);
    clear_logs();
    req(1, 1'b1, 8'h25, 8'h05);
    req(3, 1'b1, 8'h26, 8'h06);
    wait_acks("t4_acks", 2, 60);
    chk("t4_first",  32'(ak_q[0].id), 32'd3);
    chk("t4_second", 32'(ak_q[1].id), 32'd1);

    // 5: timeout, then a normal transaction
    clear_logs();
    done_dly = 0;
    req(1, 1'b1, 8'h30, 8'h77);
    wait_acks("t5_acks", 1, 60);
    chk("t5_err",   32'(ak_q[0].err),            32'd1);
    chk("t5_ack",   32'(ak_q[0].vec),            32'b0010);
    chk("t5_lat",   32'(ak_q[0].cyc - st_q[0].cyc), 32'(TIMEOUT + 1));
    chk("t5_rdata", 32'(ak_q[0].rd),             32'h5A);
    clear_logs();
    done_dly = 2;
    rd_val   = 8'hC3;
    req(0, 1'b0, 8'h31, 8'h00);
    wait_acks("t5b_acks", 1, 40);
    chk("t5b_err",   32'(ak_q[0].err), 32'd0);
    chk("t5b_ack",   32'(ak_q[0].vec), 32'b0001);
    chk("t5b_rdata", 32'(ak_q[0].rd),  32'hC3);

    // 6: asynchronous reset while waiting on the master
    clear_logs();
    done_dly = 0;
    req(3, 1'b1, 8'h40, 8'h99);
    for (int b = 0; b < 20 && st_q.size() == 0; b++) tick();
    chk("t6_started", 32'(st_q.size()), 32'd1);
    tick();
    tick();
    tick();
    #2;
    PRESETn = 1'b0;
    #1;
    chk("t6_rst_busy",  32'(bus.busy),        32'd0);
    chk("t6_rst_ack",   32'(bus.req_ack),     32'd0);
    chk("t6_rst_err",   32'(bus.req_err),     32'd0);
    chk("t6_rst_sw",    32'(bus.start_write), 32'd0);
    chk("t6_rst_sr",    32'(bus.start_read),  32'd0);
    chk("t6_rst_addr",  32'(bus.m_addr),      32'd0);
    chk("t6_rst_wdata", 32'(bus.m_wdata),     32'd0);
    chk("t6_rst_rdata", 32'(bus.rsp_rdata),   32'd0);
    chk("t6_rst_grant", 32'(bus.grant_id),    32'd0);
    bus.req_valid = '0;
    done_at       = -1;
    tick();
    tick();
    chk("t6_no_ack", 32'(ak_q.size()), 32'd0);
    clear_logs();
    done_dly = 1;
    req(2, 1'b1, 8'h42, 8'h22);
    req(0, 1'b1, 8'h41, 8'h11);
    PRESETn = 1'b1;
    wait_acks("t6_acks", 2, 40);
    chk("t6_first",  32'(ak_q[0].id), 32'd0);
    chk("t6_second", 32'(ak_q[1].id), 32'd2);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
